// File: rtl/ap_s_core.sv
// ap_s_core: word-parallel associative processor tile with A/B/C arrays in two banks
module ap_s_core #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512
) (
    input  logic                          CLK100MHZ,
    input  logic                          rst,
    input  logic [$clog2(CELL_QUANT)-1:0] addr_in,
    input  logic [WORD_SIZE-1:0]          data_in,
    input  logic                          write_en,
    input  logic                          read_en,
    input  logic [1:0]                    sel_col,
    input  logic                          sel_internal_col,
    input  logic                          op_direction,
    input  logic                          ap_mode,
    input  logic [2:0]                    cmd,
    output logic [WORD_SIZE-1:0]          data_out,
    output logic                          ap_state_irq
);
    localparam int AW = $clog2(CELL_QUANT);
    localparam int KW = $clog2(WORD_SIZE);
    localparam int SQ = WORD_SIZE * WORD_SIZE;
    localparam int CW = $clog2(CELL_QUANT > SQ ? CELL_QUANT : SQ);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    localparam logic [2:0] OP_XOR = 3'd1, OP_AND = 3'd2, OP_NOT = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4, OP_SUB = 3'd5, OP_MULT = 3'd6;
    logic [1:0]            state;
    logic [2:0]            op;
    logic                  dir;
    logic                  bank;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         last;
    logic [KW-1:0]         k;
    logic [KW-1:0]         j;
    logic [CELL_QUANT-1:0] carry;
    logic [CELL_QUANT-1:0] vres;
    logic [CELL_QUANT-1:0] vcarry;
    logic [WORD_SIZE-1:0]  ha;
    logic [WORD_SIZE-1:0]  hb;
    logic [WORD_SIZE-1:0]  hres;
    logic [WORD_SIZE-1:0]  am;
    logic                  ab;
    logic                  bb;
    logic                  cin;
    logic [WORD_SIZE-1:0]  a [2][CELL_QUANT];
    logic [WORD_SIZE-1:0]  b [2][CELL_QUANT];
    logic [WORD_SIZE-1:0]  c [2][CELL_QUANT];

    // Step datapath: full-word result for the current row, and one bit-slice across all rows.
    // Vertical MULT reuses the adder with C as the accumulator and A shifted by partial-product j.
    always_comb begin
        k = KW'(cnt % CW'(WORD_SIZE));
        j = KW'(cnt / CW'(WORD_SIZE));
        last = dir ? CW'(CELL_QUANT - 1) : (op == OP_MULT) ? CW'(SQ - 1) : CW'(WORD_SIZE - 1);
        ha = a[bank][cnt[AW-1:0]];
        hb = b[bank][cnt[AW-1:0]];
        hres = (op == OP_XOR) ? ha ^ hb : (op == OP_AND) ? ha & hb : (op == OP_NOT) ? ~ha :
               (op == OP_ADD) ? ha + hb : (op == OP_SUB) ? ha - hb : (op == OP_MULT) ? ha * hb : ha | hb;
        vres = '0;
        vcarry = '0;
        am = '0;
        ab = 1'b0;
        bb = 1'b0;
        cin = 1'b0;
        for (int r = 0; r < CELL_QUANT; r++) begin
            am = (op == OP_MULT) ? a[bank][r] << j : a[bank][r];
            ab = am[k] & (op != OP_MULT || b[bank][r][j]);
            bb = (op == OP_MULT) ? c[bank][r][k] : b[bank][r][k];
            cin = (k == '0) ? 1'b0 : carry[r];
            vcarry[r] = (op == OP_SUB) ? (~ab & bb) | (~(ab ^ bb) & cin) : (ab & bb) | (cin & (ab ^ bb));
            vres[r] = (op == OP_XOR) ? ab ^ bb : (op == OP_AND) ? ab & bb : (op == OP_NOT) ? ~ab :
                      (op == OP_ADD || op == OP_SUB || op == OP_MULT) ? ab ^ bb ^ cin : ab | bb;
        end
    end

    // Control FSM, host access and array updates; reset clears only the selected bank.
    always_ff @(posedge CLK100MHZ) begin
        if (!rst) begin
            state <= IDLE;
            data_out <= '0;
            ap_state_irq <= 1'b0;
            cnt <= '0;
            carry <= '0;
            for (int r = 0; r < CELL_QUANT; r++) begin
                a[sel_internal_col][r] <= '0;
                b[sel_internal_col][r] <= '0;
                c[sel_internal_col][r] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (ap_mode) begin
                        state <= RUN;
                        op <= cmd;
                        dir <= op_direction;
                        bank <= sel_internal_col;
                        cnt <= '0;
                        carry <= '0;
                        if (!op_direction && cmd == OP_MULT)
                            for (int r = 0; r < CELL_QUANT; r++) c[sel_internal_col][r] <= '0;
                    end else if (write_en) begin
                        if (sel_col == 2'd0) a[sel_internal_col][addr_in] <= data_in;
                        if (sel_col == 2'd1) b[sel_internal_col][addr_in] <= data_in;
                        if (sel_col == 2'd2) c[sel_internal_col][addr_in] <= data_in;
                    end else if (read_en) begin
                        data_out <= (sel_col == 2'd0) ? a[sel_internal_col][addr_in] :
                                    (sel_col == 2'd1) ? b[sel_internal_col][addr_in] :
                                    (sel_col == 2'd2) ? c[sel_internal_col][addr_in] : '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (dir) begin
                        c[bank][cnt[AW-1:0]] <= hres;
                    end else begin
                        for (int r = 0; r < CELL_QUANT; r++) c[bank][r][k] <= vres[r];
                        carry <= vcarry;
                    end
                    if (cnt == last) begin
                        state <= DONE;
                        ap_state_irq <= 1'b1;
                    end
                end
                DONE: begin
                    if (!ap_mode) begin
                        state <= IDLE;
                        ap_state_irq <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ap_s_core.sv
// tb_ap_s_core: directed scoreboard bench for the associative processor tile
module tb_ap_s_core;
    localparam int WS = 8;
    localparam int CQ = 512;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [8:0] addr_in = '0;
    logic [7:0] data_in = '0;
    logic       write_en = 1'b0;
    logic       read_en = 1'b0;
    logic [1:0] sel_col = '0;
    logic       sel_internal_col = 1'b0;
    logic       op_direction = 1'b0;
    logic       ap_mode = 1'b0;
    logic [2:0] cmd = '0;
    logic [7:0] data_out;
    logic       ap_state_irq;
    logic [7:0] ma [2][CQ];
    logic [7:0] mb [2][CQ];
    logic [7:0] mc [2][CQ];
    logic [7:0] q [$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ap_s_core #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) dut (
        .CLK100MHZ(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
        .write_en(write_en), .read_en(read_en), .sel_col(sel_col),
        .sel_internal_col(sel_internal_col), .op_direction(op_direction),
        .ap_mode(ap_mode), .cmd(cmd), .data_out(data_out), .ap_state_irq(ap_state_irq)
    );

    function automatic logic [7:0] f(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            3'd1: return x ^ y;
            3'd2: return x & y;
            3'd3: return ~x;
            3'd4: return x + y;
            3'd5: return x - y;
            3'd6: return x * y;
            default: return x | y;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] col, input logic bk, input logic [8:0] ad, input logic [7:0] d);
        sel_col = col;
        sel_internal_col = bk;
        addr_in = ad;
        data_in = d;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        if (col == 2'd0) ma[bk][ad] = d;
        if (col == 2'd1) mb[bk][ad] = d;
        if (col == 2'd2) mc[bk][ad] = d;
    endtask

    task automatic rd(input logic [1:0] col, input logic bk, input logic [8:0] ad, input string tag);
        sel_col = col;
        sel_internal_col = bk;
        addr_in = ad;
        read_en = 1'b1;
        q.push_back(col == 2'd0 ? ma[bk][ad] : col == 2'd1 ? mb[bk][ad] : col == 2'd2 ? mc[bk][ad] : 8'd0);
        tick();
        read_en = 1'b0;
        chk(tag, {24'd0, data_out}, {24'd0, q.pop_front()});
    endtask

    // latency is counted in edges after the one that accepts ap_mode=1
    task automatic run(input logic [2:0] op, input logic d, input logic bk, input int lat, input logic poke);
        int n;
        cmd = op;
        op_direction = d;
        sel_internal_col = bk;
        ap_mode = 1'b1;
        tick();
        n = 0;
        if (poke) begin
            sel_col = 2'd0;
            addr_in = '0;
            data_in = 8'h5A;
            write_en = 1'b1;
            tick();
            write_en = 1'b0;
            n = 1;
        end
        while (!ap_state_irq && n < lat + 20) begin
            tick();
            n++;
        end
        chk($sformatf("latency op%0d dir%0d", op, d), n, lat);
        repeat (3) tick();
        chk("irq_hold", {31'd0, ap_state_irq}, 32'd1);
        ap_mode = 1'b0;
        tick();
        chk("irq_drop", {31'd0, ap_state_irq}, 32'd0);
        for (int r = 0; r < CQ; r++) mc[bk][r] = f(op, ma[bk][r], mb[bk][r]);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < CQ; r++) begin
            ma[0][r] = 0; mb[0][r] = 0; mc[0][r] = 0;
            ma[1][r] = 0; mb[1][r] = 0; mc[1][r] = 0;
        end
        tick();
        tick();
        sel_internal_col = 1'b1;
        tick();
        rst = 1'b1;
        chk("reset_data_out", {24'd0, data_out}, 32'd0);
        chk("reset_irq", {31'd0, ap_state_irq}, 32'd0);
        rd(2'd2, 1'b1, 9'd7, "reset_bank1_c");
        wr(2'd0, 1'b0, 9'd5, 8'd171);
        wr(2'd1, 1'b0, 9'd5, 8'd167);
        rd(2'd0, 1'b0, 9'd5, "read_a5");
        rd(2'd1, 1'b0, 9'd5, "read_b5");
        tick();
        chk("hold_no_read", {24'd0, data_out}, {24'd0, mb[0][5]});
        sel_col = 2'd0;
        data_in = 8'd99;
        write_en = 1'b1;
        read_en = 1'b1;
        tick();
        write_en = 1'b0;
        read_en = 1'b0;
        ma[0][5] = 8'd99;
        chk("both_strobes_hold", {24'd0, data_out}, {24'd0, mb[0][5]});
        rd(2'd0, 1'b0, 9'd5, "write_won");
        wr(2'd3, 1'b0, 9'd5, 8'd77);
        rd(2'd3, 1'b0, 9'd5, "sel3_read_zero");
        rd(2'd0, 1'b0, 9'd5, "sel3_write_ignored");
        for (int i = 0; i < CQ; i++) begin
            wr(2'd0, 1'b0, 9'(i), 8'd1);
            wr(2'd1, 1'b0, 9'(i), 8'(i % 3));
        end
        run(3'd4, 1'b0, 1'b0, 8, 1'b0);
        for (int i = 0; i < CQ; i++) rd(2'd2, 1'b0, 9'(i), "vadd");
        run(3'd3, 1'b0, 1'b0, 8, 1'b0);
        run(3'd4, 1'b1, 1'b0, 512, 1'b0);
        for (int i = 0; i < CQ; i++) rd(2'd2, 1'b0, 9'(i), "hadd");
        for (int op = 0; op < 6; op++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 16; i++) begin
                    wr(2'd0, 1'b0, 9'(i), i == 0 ? 8'd3 : 8'($urandom_range(0, 255)));
                    wr(2'd1, 1'b0, 9'(i), i == 0 ? 8'd200 : 8'($urandom_range(0, 255)));
                end
                run(3'(op), d[0], 1'b0, d ? 512 : 8, 1'b0);
                for (int i = 0; i < 16; i++) rd(2'd2, 1'b0, 9'(i), $sformatf("op%0d_dir%0d", op, d));
                rd(2'd2, 1'b0, 9'd511, $sformatf("op%0d_dir%0d_last", op, d));
            end
        end
        for (int i = 0; i < 16; i++) begin
            wr(2'd0, 1'b0, 9'(i), i == 1 ? 8'd200 : 8'd15);
            wr(2'd1, 1'b0, 9'(i), i == 1 ? 8'd3 : 8'd15);
        end
        run(3'd6, 1'b0, 1'b0, 64, 1'b0);
        for (int i = 0; i < 16; i++) rd(2'd2, 1'b0, 9'(i), "vmult");
        rd(2'd2, 1'b0, 9'd300, "vmult_row300");
        run(3'd3, 1'b0, 1'b0, 8, 1'b0);
        run(3'd6, 1'b1, 1'b0, 512, 1'b0);
        for (int i = 0; i < 4; i++) rd(2'd2, 1'b0, 9'(i), "hmult");
        for (int i = 0; i < 4; i++) begin
            wr(2'd0, 1'b1, 9'(i), 8'(10 + i));
            wr(2'd1, 1'b1, 9'(i), 8'(20 + i));
        end
        run(3'd4, 1'b0, 1'b1, 8, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd(2'd2, 1'b1, 9'(i), "bank1_c");
            rd(2'd2, 1'b0, 9'(i), "bank0_c_kept");
        end
        rd(2'd0, 1'b0, 9'd0, "bank0_a_kept");
        run(3'd4, 1'b0, 1'b0, 8, 1'b1);
        rd(2'd0, 1'b0, 9'd0, "run_write_ignored_a");
        rd(2'd2, 1'b0, 9'd0, "run_write_ignored_c");
        rd(2'd0, 1'b1, 9'd2, "pre_reset_read");
        cmd = 3'd6;
        op_direction = 1'b0;
        sel_internal_col = 1'b1;
        ap_mode = 1'b1;
        tick();
        repeat (10) tick();
        rst = 1'b0;
        ap_mode = 1'b0;
        tick();
        rst = 1'b1;
        for (int r = 0; r < CQ; r++) begin
            ma[1][r] = 0; mb[1][r] = 0; mc[1][r] = 0;
        end
        chk("midrun_reset_data_out", {24'd0, data_out}, 32'd0);
        chk("midrun_reset_irq", {31'd0, ap_state_irq}, 32'd0);
        repeat (70) tick();
        chk("aborted_irq_stays_low", {31'd0, ap_state_irq}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd(2'd0, 1'b1, 9'(i), "midrun_bank1_a");
            rd(2'd2, 1'b1, 9'(i), "midrun_bank1_c");
        end
        rd(2'd2, 1'b0, 9'd1, "midrun_bank0_kept");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
